rsa_modexp_ctrl: RTL

- Initiator side of the Montgomery multiplier interface.
- Accepts one RSA job (message, exponent, modulus, R^2 mod N) and computes msg^exp mod N.
- Issues a sequence of Montgomery products (a*b*2^-MOD_WIDTH mod N) to one external multiplier, then returns the plain-domain result.
- Sits between the RSA job front-end and the Montgomery multiplier; at most one multiplier request is outstanding at any time.

---
 rtl/rsa_modexp_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rsa_modexp_ctrl.sv
// rsa_modexp_ctrl: computes msg^exp mod N by driving one external Montgomery multiplier (LSB-first square-and-multiply).
// Latency: 3 + EXP_WIDTH + popcount(exp) multiplier round trips per job, plus one cycle per handshake.
// Backpressure: one request outstanding at a time; operands held while m_ready=0; result held in DONE until o_ready.
module rsa_modexp_ctrl #(
  parameter int MOD_WIDTH = 256,
  parameter int EXP_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  // job front-end
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [MOD_WIDTH-1:0] i_msg,
  input  logic [EXP_WIDTH-1:0] i_exp,
  input  logic [MOD_WIDTH-1:0] i_modulus,
  input  logic [MOD_WIDTH-1:0] i_r2,
  // multiplier request
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [MOD_WIDTH-1:0] m_a,
  output logic [MOD_WIDTH-1:0] m_b,
  output logic [MOD_WIDTH-1:0] m_modulus,
  // multiplier response
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [MOD_WIDTH-1:0] s_out,
  // job result
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [MOD_WIDTH-1:0] o_result
);

  localparam int CNT_W = $clog2(EXP_WIDTH + 1);
  localparam logic [MOD_WIDTH-1:0] ONE      = MOD_WIDTH'(1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(EXP_WIDTH);

  typedef enum logic [2:0] {
    IDLE, CONV_BASE, CONV_ONE, MUL, SQR, CONV_OUT, DONE
  } state_t;

  state_t               state;
  logic [MOD_WIDTH-1:0] r2;
  logic [MOD_WIDTH-1:0] base;
  logic [MOD_WIDTH-1:0] acc;
  logic [EXP_WIDTH-1:0] exp_sr;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc;

  // Squares already done, including the one whose result is arriving now.
  assign cnt_inc = cnt + CNT_W'(1);

  // Job sequencer: every arithmetic state is ISSUE (m_valid=1) then WAIT (s_ready=1).
  // The next request's operands are loaded on the same edge the previous result is captured,
  // using s_out directly wherever that result is itself an operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      i_ready   <= 1'b1;
      m_valid   <= 1'b0;
      s_ready   <= 1'b0;
      o_valid   <= 1'b0;
      o_result  <= '0;
      m_a       <= '0;
      m_b       <= '0;
      m_modulus <= '0;
      r2        <= '0;
      base      <= '0;
      acc       <= '0;
      exp_sr    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            m_a       <= i_msg;
            m_b       <= i_r2;
            r2        <= i_r2;
            m_modulus <= i_modulus;
            exp_sr    <= i_exp;
            cnt       <= '0;
            i_ready   <= 1'b0;
            m_valid   <= 1'b1;
            state     <= CONV_BASE;
          end
        end
        DONE: begin
          if (o_ready) begin
            o_valid <= 1'b0;
            i_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          if (m_valid) begin
            // ISSUE phase: hold operands until the multiplier takes them.
            if (m_ready) begin
              m_valid <= 1'b0;
              s_ready <= 1'b1;
            end
          end else if (s_valid && s_ready) begin
            // WAIT phase: capture the product and launch the next request.
            s_ready <= 1'b0;
            case (state)
              CONV_BASE: begin
                base    <= s_out;
                m_a     <= ONE;
                m_b     <= r2;
                m_valid <= 1'b1;
                state   <= CONV_ONE;
              end
              CONV_ONE: begin
                acc     <= s_out;
                m_valid <= 1'b1;
                if (exp_sr[0]) begin
                  m_a   <= s_out;
                  m_b   <= base;
                  state <= MUL;
                end else begin
                  m_a   <= base;
                  m_b   <= base;
                  state <= SQR;
                end
              end
              MUL: begin
                acc     <= s_out;
                m_a     <= base;
                m_b     <= base;
                m_valid <= 1'b1;
                state   <= SQR;
              end
              SQR: begin
                base    <= s_out;
                exp_sr  <= exp_sr >> 1;
                cnt     <= cnt_inc;
                m_valid <= 1'b1;
                if (cnt_inc == CNT_LAST) begin
                  m_a   <= acc;
                  m_b   <= ONE;
                  state <= CONV_OUT;
                end else if (exp_sr[1]) begin
                  m_a   <= acc;
                  m_b   <= s_out;
                  state <= MUL;
                end else begin
                  m_a   <= s_out;
                  m_b   <= s_out;
                  state <= SQR;
                end
              end
              CONV_OUT: begin
                o_result <= s_out;
                o_valid  <= 1'b1;
                state    <= DONE;
              end
              default: begin
                state <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  // A response is only legal while a request is outstanding; stray ones are ignored by the sequencer.
  a_no_stray_resp: assert property (@(posedge clk) disable iff (rst) s_valid |-> s_ready);

endmodule
